// File: rtl/mealy_pkg.sv
// Shared defaults, width helpers and table-entry layout for the programmable Mealy machine.
package mealy_pkg;
  localparam int DEF_NUM_STATES = 8;
  localparam int DEF_IN_W       = 2;
  localparam int DEF_OUT_W      = 1;
  localparam int DEF_INIT_STATE = 0;

  // Entry fields are sized for the largest legal configuration; the next
  // field is kept full width so out-of-range targets stay detectable.
  localparam int MAX_SW    = 4;
  localparam int MAX_OUT_W = 16;

  typedef struct packed {
    logic [MAX_SW-1:0]    next;
    logic [MAX_OUT_W-1:0] out;
  } entry_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_STEP,
    OP_LOAD
  } op_e;

  function automatic int state_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int idx_w(input int n, input int in_w);
    return state_w(n) + in_w;
  endfunction
endpackage

// File: rtl/mealy_prog_if.sv
// Step, load, table-programming and status signals of one mealy_prog instance.
interface mealy_prog_if #(
  parameter int NUM_STATES = mealy_pkg::DEF_NUM_STATES,
  parameter int IN_W       = mealy_pkg::DEF_IN_W,
  parameter int OUT_W      = mealy_pkg::DEF_OUT_W
);
  localparam int SW = mealy_pkg::state_w(NUM_STATES);

  logic [IN_W-1:0]    sw_in;
  logic               ctrl_in;
  logic               load;
  logic [SW-1:0]      load_state;
  logic               cfg_we;
  logic [SW+IN_W-1:0] cfg_addr;
  logic [SW-1:0]      cfg_next;
  logic [OUT_W-1:0]   cfg_out;
  logic [SW-1:0]      state;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic               err;
  logic [15:0]        step_cnt;

  modport master (
    output sw_in, ctrl_in, load, load_state, cfg_we, cfg_addr, cfg_next, cfg_out,
    input  state, out, out_valid, err, step_cnt
  );

  modport slave (
    input  sw_in, ctrl_in, load, load_state, cfg_we, cfg_addr, cfg_next, cfg_out,
    output state, out, out_valid, err, step_cnt
  );
endinterface

// File: rtl/mealy_table.sv
// Transition table: one synchronous write port, one combinational read port.
// Reset restores every entry to a self-loop with zero output.
module mealy_table
  import mealy_pkg::*;
#(
  parameter int  NUM_STATES = DEF_NUM_STATES,
  parameter int  IN_W       = DEF_IN_W,
  parameter int  OUT_W      = DEF_OUT_W,
  localparam int SW         = state_w(NUM_STATES),
  localparam int AW         = SW + IN_W,
  localparam int DEPTH      = NUM_STATES << IN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SW-1:0]    wr_next,
  input  logic [OUT_W-1:0] wr_out,
  input  logic [AW-1:0]    rd_addr,
  output entry_t           rd_entry
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{next: MAX_SW'(i >> IN_W), out: '0};
      end
    end else if (we && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= '{next: MAX_SW'(wr_next), out: MAX_OUT_W'(wr_out)};
    end
  end

  assign rd_entry = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/mealy_prog.sv
// Programmable Mealy FSM: one table-driven transition per enabled cycle, registered output,
// sticky error on any transition or load into a state that does not exist.
module mealy_prog
  import mealy_pkg::*;
#(
  parameter int  NUM_STATES = DEF_NUM_STATES,
  parameter int  IN_W       = DEF_IN_W,
  parameter int  OUT_W      = DEF_OUT_W,
  parameter int  INIT_STATE = DEF_INIT_STATE,
  localparam int SW         = state_w(NUM_STATES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_W-1:0]    sw_in,
  input  logic               ctrl_in,
  input  logic               load,
  input  logic [SW-1:0]      load_state,
  input  logic               cfg_we,
  input  logic [SW+IN_W-1:0] cfg_addr,
  input  logic [SW-1:0]      cfg_next,
  input  logic [OUT_W-1:0]   cfg_out,
  output logic [SW-1:0]      state,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               err,
  output logic [15:0]        step_cnt
);

  entry_t             rd_entry;
  op_e                op;
  logic [SW-1:0]      state_d;
  logic [OUT_W-1:0]   out_d;
  logic               valid_d;
  logic               err_d;
  logic [15:0]        cnt_d;

  // The read sees the pre-write contents, so a same-cycle write only affects later steps.
  mealy_table #(
    .NUM_STATES (NUM_STATES),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (cfg_we),
    .wr_addr  (cfg_addr),
    .wr_next  (cfg_next),
    .wr_out   (cfg_out),
    .rd_addr  ({state, sw_in}),
    .rd_entry (rd_entry)
  );

  if (OUT_W < MAX_OUT_W) begin : g_out_pad
    logic unused_out_hi;
    assign unused_out_hi = |rd_entry.out[MAX_OUT_W-1:OUT_W];
  end

  always_comb begin
    state_d = state;
    out_d   = out;
    valid_d = 1'b0;
    err_d   = err;
    cnt_d   = step_cnt;

    if (load)         op = OP_LOAD;
    else if (ctrl_in) op = OP_STEP;
    else              op = OP_IDLE;

    case (op)
      OP_LOAD: begin
        if (int'(load_state) < NUM_STATES) state_d = load_state;
        else                               err_d   = 1'b1;
      end
      OP_STEP: begin
        if (int'(rd_entry.next) < NUM_STATES) state_d = rd_entry.next[SW-1:0];
        else                                  err_d   = 1'b1;
        out_d   = rd_entry.out[OUT_W-1:0];
        valid_d = 1'b1;
        cnt_d   = step_cnt + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SW'(INIT_STATE);
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      step_cnt  <= '0;
    end else begin
      state     <= state_d;
      out       <= out_d;
      out_valid <= valid_d;
      err       <= err_d;
      step_cnt  <= cnt_d;
    end
  end

endmodule

// File: doc/mealy_prog.md
MEALY_PROG -- requirements
Module: mealy_prog

Interface
REQ-001 Parameter NUM_STATES, default 8, number of FSM states (2..16).
REQ-002 Parameter IN_W, default 2, width of the symbol input.
REQ-003 Parameter OUT_W, default 1, width of the per-transition output.
REQ-004 Parameter INIT_STATE, default 0, state entered on reset.
REQ-005 The port list SHALL be one clock and one asynchronous active-high reset, named clk and reset, followed by the ports below.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 sw_in  input  IN_W  input symbol for the current step.
REQ-009 ctrl_in  input  1  step enable; one transition per cycle when high.
REQ-010 load  input  1  synchronous state override.
REQ-011 load_state  input  SW=clog2(NUM_STATES)  state written by load.
REQ-012 cfg_we  input  1  table write enable.
REQ-013 cfg_addr  input  SW+IN_W  table index {state, symbol}.
REQ-014 cfg_next  input  SW  next-state field written.
REQ-015 cfg_out  input  OUT_W  output field written.
REQ-016 state  output  SW  current state register.
REQ-017 out  output  OUT_W  registered Mealy output of the last step.
REQ-018 out_valid  output  1  one-cycle pulse, high the cycle after each accepted step.
REQ-019 err  output  1  sticky illegal-transition flag.
REQ-020 step_cnt  output  16  count of accepted steps.

Function
REQ-021 Transition table SHALL hold NUM_STATES*2^IN_W entries of {next, out}, indexed {state, sw_in}.
REQ-022 When ctrl_in=1 and load=0 at a rising edge: state<=table[{state,sw_in}].next, out<=table[{state,sw_in}].out, out_valid<=1, step_cnt<=step_cnt+1.
REQ-023 When ctrl_in=0 and load=0: state, out, step_cnt SHALL hold; out_valid<=0.
REQ-024 load=1 SHALL set state<=load_state, out_valid<=0, leave out and step_cnt unchanged, and take priority over ctrl_in.
REQ-025 A table entry whose next >= NUM_STATES, or load_state >= NUM_STATES, SHALL leave state unchanged and set err<=1; err clears only on reset.
REQ-026 An illegal step SHALL still update out, pulse out_valid and increment step_cnt.
REQ-027 cfg_we=1 SHALL write {cfg_next,cfg_out} to table[cfg_addr] at the rising edge.
REQ-028 Simultaneous cfg_we and step on the same index: the step SHALL use the pre-write entry; the new entry is visible from the next cycle.
REQ-029 step_cnt SHALL wrap from 16'hFFFF to 0 without setting err.
REQ-030 Lookup SHALL be combinational from state and sw_in; latency from ctrl_in to state/out is exactly one cycle.

Reset
REQ-031 reset=1 SHALL asynchronously set state=INIT_STATE, out=0, out_valid=0, err=0, step_cnt=0.
REQ-032 reset SHALL initialise every table entry to {next=own state index, out=0} (self-loop).
REQ-033 reset asserted mid-run SHALL discard any in-flight step and cfg write in that cycle.

Structure
REQ-034 Package mealy_pkg SHALL hold the default parameters, the state/index width functions and the table-entry struct {next, out}.
REQ-035 The table SHALL be a sub-module mealy_table: one synchronous write port, one combinational read port, asynchronous reset to the self-loop contents.

Verification
REQ-036 Defaults, reset, program {s0:1->s2/0, s2:0->s0/1}, sw_in=1 then 0 with ctrl_in=1 -> state 2,out 0 then state 0,out 1; step_cnt=2.
REQ-037 After reset, no programming, ctrl_in=1 for 5 cycles with sw_in=3 -> state stays 0, out=0, out_valid high 5 cycles, step_cnt=5.
REQ-038 NUM_STATES=5: program entry {s0,0}->next 6, step -> state 0, err=1, step_cnt=1; err persists until reset.
REQ-039 load=1, load_state=3 with ctrl_in=1 same cycle -> state 3, out_valid=0, step_cnt unchanged.
REQ-040 cfg_we writes {s0,2}->next 1 while stepping from s0 with sw_in=2 (old entry self-loop) -> state 0; next step with sw_in=2 -> state 1.
REQ-041 Preset step_cnt to 16'hFFFF by stepping, one more step -> step_cnt=0, err=0; reset mid-step -> all outputs at reset values.
